// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake and iterative or barrel shifter.
// Define ALU_EXEC_BARREL_SHIFT_EN for single-cycle shifts.
module alu_exec_unit #(
   parameter  int XLEN = 32,
   localparam int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      alu_ctl,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   localparam logic [3:0] C_AND = 4'b0000;
   localparam logic [3:0] C_OR  = 4'b0001;
   localparam logic [3:0] C_ADD = 4'b0010;
   localparam logic [3:0] C_SUB = 4'b0110;
   localparam logic [3:0] C_SLL = 4'b0011;
   localparam logic [3:0] C_SRL = 4'b0100;
   localparam logic [3:0] C_SRA = 4'b0101;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t          r_state;
   logic [XLEN-1:0] r_result;
   logic            r_zero;
   logic            r_illegal;

   logic [XLEN-1:0] w_res;
   logic            w_legal;
   logic            w_is_shift;
   logic [SHW-1:0]  w_shamt;
   logic            w_accept;

   assign w_shamt  = op_b[SHW-1:0];
   assign in_ready = (r_state == IDLE);
   assign out_valid = (r_state == RESP);
   assign w_accept = in_valid && in_ready;
   assign result   = r_result;
   assign zero     = r_zero;
   assign illegal  = r_illegal;

   always_comb begin
      w_res      = '0;
      w_legal    = 1'b1;
      w_is_shift = 1'b0;
      case (alu_ctl)
         C_AND: w_res = op_a & op_b;
         C_OR:  w_res = op_a | op_b;
         C_ADD: w_res = op_a + op_b;
         C_SUB: w_res = op_a + ~op_b + 1'b1;
`ifdef ALU_EXEC_BARREL_SHIFT_EN
         C_SLL: begin
            w_is_shift = 1'b1;
            w_res      = op_a << w_shamt;
         end
         C_SRL: begin
            w_is_shift = 1'b1;
            w_res      = op_a >> w_shamt;
         end
         C_SRA: begin
            w_is_shift = 1'b1;
            w_res      = XLEN'($signed(op_a) >>> w_shamt);
         end
`else
         // zero-amount shifts pass op_a straight through
         C_SLL, C_SRL, C_SRA: begin
            w_is_shift = 1'b1;
            w_res      = op_a;
         end
`endif
         default: w_legal = 1'b0;
      endcase
   end

`ifdef ALU_EXEC_BARREL_SHIFT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_result  <= '0;
         r_zero    <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_result  <= w_res;
                  r_zero    <= (w_res == '0);
                  r_illegal <= !w_legal;
                  r_state   <= RESP;
               end
            end
            RESP: begin
               if (out_ready) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   logic w_unused;
   assign w_unused = w_is_shift;
`else
   logic [SHW-1:0]  r_cnt;
   logic [3:0]      r_ctl;
   logic [XLEN-1:0] w_step;

   always_comb begin
      w_step = r_result;
      case (r_ctl)
         C_SLL:   w_step = {r_result[XLEN-2:0], 1'b0};
         C_SRL:   w_step = {1'b0, r_result[XLEN-1:1]};
         C_SRA:   w_step = {r_result[XLEN-1], r_result[XLEN-1:1]};
         default: w_step = r_result;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_result  <= '0;
         r_zero    <= 1'b0;
         r_illegal <= 1'b0;
         r_cnt     <= '0;
         r_ctl     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_is_shift && (w_shamt != '0)) begin
                     r_result <= op_a;
                     r_cnt    <= w_shamt;
                     r_ctl    <= alu_ctl;
                     r_state  <= SHIFT;
                  end else begin
                     r_result  <= w_res;
                     r_zero    <= (w_res == '0);
                     r_illegal <= !w_legal;
                     r_state   <= RESP;
                  end
               end
            end
            SHIFT: begin
               r_result <= w_step;
               r_cnt    <= r_cnt - 1'b1;
               if (r_cnt == SHW'(1)) begin
                  r_zero    <= (w_step == '0);
                  r_illegal <= 1'b0;
                  r_state   <= RESP;
               end
            end
            RESP: begin
               if (out_ready) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit against a behavioural model.
`timescale 1ns/1ps
module tb_alu_exec_unit;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [3:0]      alu_ctl = '0;
   logic [XLEN-1:0] op_a = '0;
   logic [XLEN-1:0] op_b = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [XLEN-1:0] result;
   logic            zero;
   logic            illegal;

   int checks = 0;
   int failures = 0;

   alu_exec_unit #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .alu_ctl(alu_ctl), .op_a(op_a), .op_b(op_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .illegal(illegal)
   );

   always #5 clk = ~clk;

   function automatic logic [XLEN-1:0] m_res(input logic [3:0] c,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
      int sh;
      longint sa;
      sh = int'(b % XLEN);
      sa = longint'($signed(a));
      case (c)
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0010: return XLEN'(64'(a) + 64'(b));
         4'b0110: return XLEN'(64'(a) - 64'(b));
         4'b0011: return XLEN'(64'(a) * (64'd1 << sh));
         4'b0100: return XLEN'(64'(a) / (64'd1 << sh));
         4'b0101: return XLEN'(sa >>> sh);
         default: return '0;
      endcase
   endfunction

   function automatic bit m_ill(input logic [3:0] c);
      return !(c inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd3, 4'd4, 4'd5});
   endfunction

   function automatic int m_lat(input logic [3:0] c, input logic [XLEN-1:0] b);
      int sh;
      sh = int'(b % XLEN);
`ifdef ALU_EXEC_BARREL_SHIFT_EN
      return 1;
`else
      if (c inside {4'd3, 4'd4, 4'd5} && sh > 0) return sh;
      return 1;
`endif
   endfunction

   // Issue one op, wait for the response, hold it `hold` cycles, then release.
   task automatic run_op(input logic [3:0] c, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input int hold,
                         output logic [XLEN-1:0] r, output logic z,
                         output logic il, output int lat);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (!in_ready) begin
         checks++; failures++;
         $display("FAIL in_ready_timeout got=%0b want=1", in_ready);
      end
      in_valid = 1'b1; alu_ctl = c; op_a = a; op_b = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      op_a = $urandom; op_b = $urandom; alu_ctl = 4'($urandom);
      lat = 0;
      do begin
         lat++;
         if (lat > 1) begin
            @(posedge clk); #1;
         end else if (!out_valid) begin
            @(posedge clk); #1;
         end
      end while (!out_valid && lat < 100);
      r = result; z = zero; il = illegal;
      repeat (hold) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({in_ready, out_valid, result, zero, illegal} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset got rdy=%0b ov=%0b res=%h z=%0b il=%0b want 1 0 0 0 0",
                  in_ready, out_valid, result, zero, illegal);
      end
   endtask

   task automatic test_add_sub();
      logic [XLEN-1:0] r; logic z, il; int lat;
      run_op(4'b0010, 5, 7, 0, r, z, il, lat);
      checks++;
      if ({r, z, il} !== {32'd12, 1'b0, 1'b0} || lat !== 1) begin
         failures++;
         $display("FAIL add got r=%h z=%0b il=%0b lat=%0d want 0000000c 0 0 1", r, z, il, lat);
      end
      run_op(4'b0110, 9, 9, 0, r, z, il, lat);
      checks++;
      if ({r, z} !== {32'd0, 1'b1}) begin
         failures++;
         $display("FAIL sub_eq got r=%h z=%0b want 0 1", r, z);
      end
      run_op(4'b0110, 3, 5, 0, r, z, il, lat);
      checks++;
      if ({r, z} !== {32'hFFFFFFFE, 1'b0}) begin
         failures++;
         $display("FAIL sub_neg got r=%h z=%0b want fffffffe 0", r, z);
      end
   endtask

   task automatic test_shift();
      logic [XLEN-1:0] r; logic z, il; int lat;
      run_op(4'b0011, 1, 31, 0, r, z, il, lat);
      checks++;
      if (r !== 32'h80000000 || lat !== m_lat(4'b0011, 31)) begin
         failures++;
         $display("FAIL sll31 got r=%h lat=%0d want 80000000 %0d", r, lat, m_lat(4'b0011, 31));
      end
      run_op(4'b0101, 32'h80000000, 4, 0, r, z, il, lat);
      checks++;
      if (r !== 32'hF8000000 || lat !== m_lat(4'b0101, 4)) begin
         failures++;
         $display("FAIL sra4 got r=%h lat=%0d want f8000000 %0d", r, lat, m_lat(4'b0101, 4));
      end
      run_op(4'b0100, 32'h80000000, 4, 0, r, z, il, lat);
      checks++;
      if (r !== 32'h08000000) begin
         failures++;
         $display("FAIL srl4 got r=%h want 08000000", r);
      end
      run_op(4'b0100, 32'h1234, 32'hFFFFFF00, 0, r, z, il, lat);
      checks++;
      if (r !== 32'h1234 || lat !== 1) begin
         failures++;
         $display("FAIL shamt0 got r=%h lat=%0d want 00001234 1", r, lat);
      end
   endtask

   task automatic test_backpressure();
      int n;
      n = 0;
      in_valid = 1'b1; alu_ctl = 4'b0000;
      op_a = 32'hF0F0F0F0; op_b = 32'hFF00FF00;
      @(posedge clk); #1;
      in_valid = 1'b0;
      while (!out_valid && n < 10) begin
         @(posedge clk); #1; n++;
      end
      in_valid = 1'b1; alu_ctl = 4'b0010; op_a = 1; op_b = 1;
      repeat (3) begin
         checks++;
         if (result !== 32'hF000F000 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL hold got r=%h rdy=%0b ov=%0b want f000f000 0 1",
                     result, in_ready, out_valid);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL release got rdy=%0b ov=%0b want 1 0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL ignored_req got ov=%0b want 0", out_valid);
      end
   endtask

   task automatic test_illegal();
      logic [XLEN-1:0] r; logic z, il; int lat;
      run_op(4'b1111, 32'hDEAD, 32'hBEEF, 0, r, z, il, lat);
      checks++;
      if ({r, z, il} !== {32'd0, 1'b1, 1'b1} || lat !== 1) begin
         failures++;
         $display("FAIL illegal got r=%h z=%0b il=%0b lat=%0d want 0 1 1 1", r, z, il, lat);
      end
      run_op(4'b0001, 0, 0, 0, r, z, il, lat);
      checks++;
      if ({r, z, il} !== {32'd0, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL or_zero got r=%h z=%0b il=%0b want 0 1 0", r, z, il);
      end
   endtask

   task automatic test_reset_mid();
      logic [XLEN-1:0] r; logic z, il; int lat;
      run_op(4'b0010, 32'h55, 32'h22, 0, r, z, il, lat);
      in_valid = 1'b1; alu_ctl = 4'b0100; op_a = 32'hFFFF0000; op_b = 20;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, result, zero, illegal, in_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL mid_reset got ov=%0b r=%h z=%0b il=%0b rdy=%0b want 0 0 0 0 1",
                  out_valid, result, zero, illegal, in_ready);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL post_reset got rdy=%0b ov=%0b want 1 0", in_ready, out_valid);
      end
      run_op(4'b0010, 1, 1, 0, r, z, il, lat);
      checks++;
      if (r !== 32'd2) begin
         failures++;
         $display("FAIL add_after_reset got r=%h want 2", r);
      end
   endtask

   task automatic test_random();
      logic [XLEN-1:0] r, a, b; logic z, il; int lat;
      logic [3:0] c;
      logic [XLEN-1:0] er;
      for (int i = 0; i < 60; i++) begin
         c = (i % 3 == 0) ? 4'($urandom) : 4'($urandom_range(0, 6));
         a = $urandom;
         b = (i % 5 == 0) ? a : $urandom;
         if (i % 7 == 0) a = '0;
         run_op(c, a, b, $urandom_range(0, 2), r, z, il, lat);
         er = m_res(c, a, b);
         checks++;
         if (r !== er || z !== (er == '0) || il !== m_ill(c) || lat !== m_lat(c, b)) begin
            failures++;
            $display("FAIL rand%0d ctl=%h a=%h b=%h got r=%h z=%0b il=%0b lat=%0d want %h %0b %0b %0d",
                     i, c, a, b, r, z, il, lat, er, er == '0, m_ill(c), m_lat(c, b));
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      in_valid = 1'b1; alu_ctl = 4'b0010; op_a = 10; op_b = 20;
      out_ready = 1'b1;
      n = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            n++;
            checks++;
            if (result !== 32'd30 || in_ready !== 1'b0) begin
               failures++;
               $display("FAIL b2b got r=%h rdy=%0b want 0000001e 0", result, in_ready);
            end
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      checks++;
      if (n !== 3) begin
         failures++;
         $display("FAIL b2b_count got %0d want 3", n);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #12 rst_n = 1'b0;
      #1;
      test_reset();
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_add_sub();
      test_shift();
      test_backpressure();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
